// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the serial binary-to-BCD converter.
// Holds the converter FSM encoding and a digit-count helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Decimal digits needed for the largest BIN_W-bit value: floor(w*log10(2))+1.
  function automatic int digits_needed(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Digit correction before the shift
  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one bin bit per cycle,
// with saturating overflow and a leading-zero digit mask.
module bin2bcd_serial
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  ovf
);

  localparam int                CNT_W     = $clog2(BIN_W + 1);
  localparam int                DW        = 4 * DIGITS;
  localparam bit                CAN_OVF   = (DIGITS < digits_needed(BIN_W));
  localparam logic [DW-1:0]     ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] LZ_RST    = {DIGITS{1'b1}} << 1;

  state_t             state_r, state_s;
  logic [BIN_W-1:0]   shift_r;
  logic [DW-1:0]      dig_r, adj_s, dig_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               sovf_r, ovf_s, allz_s;
  logic               load_s, shift_s, fin_s;
  logic [DIGITS-1:0]  lz_s;
  logic               ready_r, done_r, ovf_r;
  logic [DW-1:0]      bcd_r;
  logic [DIGITS-1:0]  lz_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (dig_r[4*g +: 4]),
      .q (adj_s[4*g +: 4])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_s = (cnt_r == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    load_s  = (state_r == ST_IDLE) && start;
    shift_s = (state_r == ST_SHIFT);
    fin_s   = shift_s && (cnt_r == CNT_W'(1));
  end

  // Post-shift digit view, used both for the datapath and the final result
  always_comb begin
    dig_s  = {adj_s[DW-2:0], shift_r[BIN_W-1]};
    ovf_s  = CAN_OVF ? (sovf_r | adj_s[DW-1]) : 1'b0;
    allz_s = 1'b1;
    lz_s   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz_s  = allz_s & (dig_s[4*i +: 4] == 4'd0);
      lz_s[i] = allz_s;
    end
  end

  // Conversion datapath: load, then shift one bin bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
      dig_r   <= '0;
      cnt_r   <= '0;
      sovf_r  <= 1'b0;
    end else if (load_s) begin
      shift_r <= bin;
      dig_r   <= '0;
      cnt_r   <= CNT_W'(BIN_W);
      sovf_r  <= 1'b0;
    end else if (shift_s) begin
      shift_r <= {shift_r[BIN_W-2:0], 1'b0};
      dig_r   <= dig_s;
      cnt_r   <= cnt_r - CNT_W'(1);
      sovf_r  <= sovf_r | adj_s[DW-1];
    end else begin
      shift_r <= shift_r;
      dig_r   <= dig_r;
      cnt_r   <= cnt_r;
      sovf_r  <= sovf_r;
    end
  end

  // Registered outputs; the result is captured on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      bcd_r   <= '0;
      lz_r    <= LZ_RST;
      ovf_r   <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      if (fin_s) begin
        bcd_r <= ovf_s ? ALL_NINES : dig_s;
        lz_r  <= ovf_s ? '0 : lz_s;
        ovf_r <= ovf_s;
      end else begin
        bcd_r <= bcd_r;
        lz_r  <= lz_r;
        ovf_r <= ovf_r;
      end
    end
  end

  assign ready   = ready_r;
  assign done    = done_r;
  assign bcd     = bcd_r;
  assign lz_mask = lz_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: 8-digit and 6-digit instances,
// expected results queued at start and compared when done pulses.
module tb_bin2bcd_serial;

  logic        clk = 1'b0;
  logic        rst_n, start, start6;
  logic [23:0] bin, bin6;
  logic        ready, done, ovf;
  logic [31:0] bcd;
  logic [7:0]  lz;
  logic        ready6, done6, ovf6;
  logic [23:0] bcd6;
  logic [5:0]  lz6;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  lz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb6[$];

  always #5 clk = ~clk;

  bin2bcd_serial #(.BIN_W(24), .DIGITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .ready(ready), .done(done), .bcd(bcd), .lz_mask(lz), .ovf(ovf)
  );

  bin2bcd_serial #(.BIN_W(24), .DIGITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .bin(bin6),
    .ready(ready6), .done(done6), .bcd(bcd6), .lz_mask(lz6), .ovf(ovf6)
  );

  // Decimal reference model
  function automatic exp_t model(input logic [23:0] v, input int nd);
    exp_t e;
    longint unsigned lim = 1;
    int unsigned r;
    logic allz;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.bcd = '0;
    e.lz  = '0;
    e.ovf = (longint'(v) >= lim);
    r = 32'(v);
    if (e.ovf) begin
      for (int i = 0; i < nd; i++) e.bcd[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < nd; i++) begin
        e.bcd[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
      allz = 1'b1;
      for (int i = nd - 1; i >= 1; i--) begin
        allz = allz & (e.bcd[4*i +: 4] == 4'd0);
        e.lz[i] = allz;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start6 = 1'b0; bin = '0; bin6 = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL reset_bcd got %h want 0", bcd); end
    checks++; if (lz !== 8'hFE) begin errors++; $display("FAIL reset_lz got %h want fe", lz); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (lz6 !== 6'h3E) begin errors++; $display("FAIL reset_lz6 got %h want 3e", lz6); end
    rst_n = 1'b1;
  endtask

  task automatic test_values();
    logic [23:0] tbl [0:6];
    exp_t e;
    int got;
    tbl[0] = 24'd0;       tbl[1] = 24'd16777215; tbl[2] = 24'd1;
    tbl[3] = 24'd10;      tbl[4] = 24'd9999999;  tbl[5] = 24'd10000000;
    tbl[6] = 24'd42;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bin = tbl[k]; start = 1'b1;
      sb.push_back(model(tbl[k], 8));
      @(posedge clk); #1;
      start = 1'b0; bin = 24'hA5A5A5;
      got = 0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (j == 1) begin
          checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready val=%0d got %b want 0", tbl[k], ready); end
        end
        if (done === 1'b1) begin got = j; break; end
      end
      checks++; if (got != 25) begin errors++; $display("FAIL latency val=%0d got %0d want 25", tbl[k], got); end
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL scoreboard_empty got 0 entries want 1");
      end else begin
        e = sb.pop_front();
        checks++; if (bcd !== e.bcd) begin errors++; $display("FAIL bcd val=%0d got %h want %h", tbl[k], bcd, e.bcd); end
        checks++; if (lz !== e.lz) begin errors++; $display("FAIL lz val=%0d got %h want %h", tbl[k], lz, e.lz); end
        checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL ovf val=%0d got %b want %b", tbl[k], ovf, e.ovf); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width val=%0d got %b want 0", tbl[k], done); end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int ndone = 0;
    int first = 0;
    @(negedge clk);
    bin = 24'd123456; start = 1'b1;
    sb.push_back(model(24'd123456, 8));
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = j;
          e = sb.pop_front();
          checks++; if (bcd !== e.bcd) begin errors++; $display("FAIL ign_bcd got %h want %h", bcd, e.bcd); end
          checks++; if (lz !== e.lz) begin errors++; $display("FAIL ign_lz got %h want %h", lz, e.lz); end
        end
      end
      if (j == 5 || j == 24) begin start = 1'b1; bin = 24'd999; end
      else begin start = 1'b0; end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", ndone); end
    checks++; if (first != 25) begin errors++; $display("FAIL ign_latency got %0d want 25", first); end
  endtask

  task automatic test_overflow6();
    logic [23:0] vals [0:1];
    exp_t e;
    int got;
    vals[0] = 24'd1000000; vals[1] = 24'd999999;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bin6 = vals[k]; start6 = 1'b1;
      sb6.push_back(model(vals[k], 6));
      @(posedge clk); #1;
      start6 = 1'b0;
      got = 0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (done6 === 1'b1) begin got = j; break; end
      end
      checks++; if (got != 25) begin errors++; $display("FAIL d6_latency val=%0d got %0d want 25", vals[k], got); end
      e = sb6.pop_front();
      checks++; if ({8'h00, bcd6} !== e.bcd) begin errors++; $display("FAIL d6_bcd val=%0d got %h want %h", vals[k], bcd6, e.bcd); end
      checks++; if ({2'b00, lz6} !== e.lz) begin errors++; $display("FAIL d6_lz val=%0d got %h want %h", vals[k], lz6, e.lz); end
      checks++; if (ovf6 !== e.ovf) begin errors++; $display("FAIL d6_ovf val=%0d got %b want %b", vals[k], ovf6, e.ovf); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int got;
    @(negedge clk);
    bin = 24'd777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL mid_bcd got %h want 0", bcd); end
    checks++; if (lz !== 8'hFE) begin errors++; $display("FAIL mid_lz got %h want fe", lz); end
    @(negedge clk);
    rst_n = 1'b1; bin = 24'd314159; start = 1'b1;
    sb.push_back(model(24'd314159, 8));
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = j; break; end
    end
    checks++; if (got != 25) begin errors++; $display("FAIL mid_latency got %0d want 25", got); end
    e = sb.pop_front();
    checks++; if (bcd !== e.bcd) begin errors++; $display("FAIL mid_bcd2 got %h want %h", bcd, e.bcd); end
    checks++; if (lz !== e.lz) begin errors++; $display("FAIL mid_lz2 got %h want %h", lz, e.lz); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_done;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n <= 26000; n++) begin
      if (n > 0) begin
        exp_done = ((n % 26) == 25);
        checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done edge=%0d got %b want %b", n, done, exp_done); end
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL b2b_empty edge=%0d got 0 entries want 1", n);
          end else begin
            e = sb.pop_front();
            checks++; if (bcd !== e.bcd) begin errors++; $display("FAIL b2b_bcd edge=%0d got %h want %h", n, bcd, e.bcd); end
            checks++; if (lz !== e.lz || ovf !== e.ovf) begin errors++; $display("FAIL b2b_lz_ovf edge=%0d got %h/%b want %h/%b", n, lz, ovf, e.lz, e.ovf); end
          end
        end
      end
      if (n == 26000) begin
        start = 1'b0;
      end else begin
        bin = 24'($urandom());
        if ((n % 26) == 0) sb.push_back(model(bin, 8));
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_values();
    test_ignore_start();
    test_overflow6();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bin2bcd_serial.md
BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

Interface
REQ-001 SHALL have parameter BIN_W, default 24, binary input width (>=4).
REQ-002 SHALL have parameter DIGITS, default 8, BCD output digit count (>=1).
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request conversion of bin.
REQ-006 SHALL have port bin, input, BIN_W, unsigned binary value, sampled only when start is accepted.
REQ-007 SHALL have port ready, output, 1, high when the block accepts start.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port bcd, output, 4*DIGITS, packed BCD with digit 0 (LSB) at bits [3:0].
REQ-010 SHALL have port lz_mask, output, DIGITS, bit i high when digit i is a leading zero.
REQ-011 SHALL have port ovf, output, 1, high when the last result exceeded 10^DIGITS-1.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE; ready = (state==IDLE).
REQ-013 SHALL, in IDLE with start=1, load bin into a shift register, clear the digit registers and the sticky overflow, set the bit counter to BIN_W and go to SHIFT.
REQ-014 SHALL ignore start whenever ready=0; bin changes during conversion SHALL have no effect.
REQ-015 SHALL, per SHIFT cycle, add 3 to every digit >=5, then shift {digits, shift register} left by one, MSB of bin first.
REQ-016 SHALL set the sticky overflow when a 1 shifts out of bit 3 of digit DIGITS-1.
REQ-017 SHALL go to DONE after exactly BIN_W SHIFT cycles, and go from DONE to IDLE unconditionally after one cycle.
REQ-018 SHALL assert done only in DONE: high exactly BIN_W+1 cycles after the accepting edge; throughput one conversion per BIN_W+2 cycles.
REQ-019 SHALL update bcd, lz_mask and ovf on the edge entering DONE and hold them until the next DONE.
REQ-020 SHALL saturate bcd to all digits 9 when overflow is set.
REQ-021 SHALL compute lz_mask[i]=1 when digits i..DIGITS-1 are all zero, for i>=1; lz_mask[0] SHALL always be 0; lz_mask SHALL be all zero on overflow.
REQ-022 SHALL accept start sampled in the IDLE cycle directly following DONE.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-conversion, force state IDLE, ready=1, done=0, bcd=0, ovf=0, lz_mask = all ones except bit 0, and abort the conversion with no done pulse.
REQ-024 SHALL leave reset synchronously to clk, with the first start accepted on the first rising edge after rst_n rises.

Structure
REQ-025 SHALL place the FSM state enum and a digits_needed(BIN_W) constant function in shared package bin2bcd_pkg.
REQ-026 SHALL use one combinational sub-module bcd_add3 (4-bit in, 4-bit out, +3 if >=5), instantiated DIGITS times via generate.
REQ-027 SHALL contain no combinational path from start or bin to any output.

Verification (BIN_W=24, DIGITS=8 unless stated)
REQ-028 SHALL cover: bin=0, start at edge 0 -> done high at edge 25, bcd=32'h00000000, lz_mask=8'hFE, ovf=0.
REQ-029 SHALL cover: bin=16777215 -> bcd=32'h16777215, lz_mask=8'h00, ovf=0.
REQ-030 SHALL cover: bin=123456 -> bcd=32'h00123456, lz_mask=8'hC0; start pulsed again at edges 5 and 24 -> ignored, exactly one done pulse.
REQ-031 SHALL cover: DIGITS=6, bin=1000000 -> ovf=1, bcd=24'h999999, lz_mask=6'h00; next bin=999999 -> ovf=0, bcd=24'h999999.
REQ-032 SHALL cover: rst_n low at edge 10 of a conversion -> no done, bcd=0, ready=1; a new start then completes normally after BIN_W+1 cycles.
REQ-033 SHALL cover: start held high continuously with 1000 random bin values -> done every 26 cycles, each bcd matching a reference decimal model.
